// File: rtl/sc_argmax_decoder_if.sv
// Bus between the classifier's second neuron layer and the argmax decoder:
// per-class bitstreams plus start in, status and classification result out.
interface sc_argmax_decoder_if #(
  parameter int N      = 10,
  parameter int L_LOG2 = 8,
  parameter int IDX_W  = 4
);
  logic              start;
  logic [N-1:0]      din;
  logic              busy;
  logic              valid;
  logic [IDX_W-1:0]  class_idx;
  logic [L_LOG2:0]   max_count;
  logic              tie;

  modport master (
    output start, din,
    input  busy, valid, class_idx, max_count, tie
  );

  modport slave (
    input  start, din,
    output busy, valid, class_idx, max_count, tie
  );
endinterface

// File: rtl/sc_argmax_decoder.sv
// Stochastic-computing argmax decoder: counts ones per class over a 2^L_LOG2
// window after a warm-up, then scans the counts to pick the winning class.

module sc_argmax_lane #(
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic          b,
  output logic [CW-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (reset || clr)  cnt <= '0;
    else if (en && b)  cnt <= cnt + CW'(1);
  end
endmodule

module sc_argmax_decoder #(
  parameter int N      = 10,
  parameter int L_LOG2 = 8,
  parameter int WARMUP = 2,
  parameter int IDX_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sc_argmax_decoder_if.slave    bus
);
  localparam int CW = L_LOG2 + 1;
  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WW-1:0]    WARM_LAST = WW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [IDX_W-1:0] SCAN_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, WARM, ACCUM, SCAN} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [CW-1:0]    cnt;
    logic             tie;
  } result_t;

  state_t               state, nstate;
  logic [WW-1:0]        warm_cnt;
  logic [L_LOG2-1:0]    win_cnt;
  logic [IDX_W-1:0]     scan_idx;
  logic [N-1:0][CW-1:0] cnt;
  logic [CW-1:0]        cur;
  result_t              best_q, best_d, res_q;
  logic                 valid_q;
  logic                 busy, clr, acc_en, scan_en;
  logic                 warm_done, win_done, scan_done;

  assign warm_done = (warm_cnt == WARM_LAST);
  assign win_done  = &win_cnt;
  assign scan_done = (scan_idx == SCAN_LAST);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // FSM: next state
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (bus.start) nstate = (WARMUP > 0) ? WARM : ACCUM;
      WARM:  if (warm_done) nstate = ACCUM;
      ACCUM: if (win_done)  nstate = SCAN;
      SCAN:  if (scan_done) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy    = (state != IDLE);
    clr     = (state == IDLE) && bus.start;
    acc_en  = (state == ACCUM);
    scan_en = (state == SCAN);
  end

  // Phase counters; each returns to 0 on leaving its state so the next
  // window starts clean without an explicit clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      warm_cnt <= '0;
      win_cnt  <= '0;
      scan_idx <= '0;
    end else begin
      if (state == WARM) warm_cnt <= warm_done ? '0 : warm_cnt + WW'(1);
      if (acc_en)        win_cnt  <= win_cnt + L_LOG2'(1);
      if (scan_en)       scan_idx <= scan_done ? '0 : scan_idx + IDX_W'(1);
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    sc_argmax_lane #(.CW(CW)) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .en    (acc_en),
      .b     (bus.din[g]),
      .cnt   (cnt[g])
    );
  end

  always_comb begin
    cur = '0;
    for (int i = 0; i < N; i++)
      if (scan_idx == IDX_W'(i)) cur = cnt[i];
  end

  // Strict greater-than keeps the lowest index on equal counts.
  always_comb begin
    best_d = best_q;
    if (scan_idx == '0) begin
      best_d.idx = '0;
      best_d.cnt = cur;
      best_d.tie = 1'b0;
    end else if (cur > best_q.cnt) begin
      best_d.idx = scan_idx;
      best_d.cnt = cur;
      best_d.tie = 1'b0;
    end else if (cur == best_q.cnt) begin
      best_d.tie = 1'b1;
    end
  end

  // The last scan step's comparison goes straight into the result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      best_q  <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (scan_en) begin
        best_q <= best_d;
        if (scan_done) begin
          res_q   <= best_d;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.valid     = valid_q;
  assign bus.class_idx = res_q.idx;
  assign bus.max_count = res_q.cnt;
  assign bus.tie       = res_q.tie;
endmodule

// File: tb/tb_sc_argmax_decoder.sv
// Randomised and directed bench for sc_argmax_decoder against a count/argmax model.
module tb_sc_argmax_decoder;
  localparam int N      = 10;
  localparam int L_LOG2 = 8;
  localparam int WARMUP = 2;
  localparam int IDX_W  = 4;
  localparam int W_LEN  = 1 << L_LOG2;
  localparam int LAT    = WARMUP + W_LEN + N + 1;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   exp_idx, exp_max;
  bit   exp_tie;

  sc_argmax_decoder_if #(.N(N), .L_LOG2(L_LOG2), .IDX_W(IDX_W)) bus ();

  sc_argmax_decoder #(.N(N), .L_LOG2(L_LOG2), .WARMUP(WARMUP), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // din for cycle c of a window (c=0 is the start cycle)
  function automatic logic [N-1:0] gen(input int mode, input int c);
    logic [N-1:0] d;
    int a;
    d = '0;
    a = c - WARMUP - 1;
    case (mode)
      0: d[3] = 1'b1;
      1: d = '0;
      2: begin d[7] = 1'b1; d[2] = 1'b1; end
      3: begin
        if (c >= 1 && c <= WARMUP) d[9] = 1'b1;
        if (a >= 0) begin
          d[5] = (a % 2 == 0);
          d[1] = (a % 4 == 0);
        end
      end
      4: d = N'($urandom);
      default: begin
        for (int i = 0; i < N; i++) d[i] = ($urandom_range(3, 0) == 0);
        d[8] = d[4];
      end
    endcase
    return d;
  endfunction

  task automatic run_window(input int mode, input bit inject, input bit chain);
    int cnt [N];
    int horiz, mx, nmx, bi;
    logic [N-1:0] d;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    horiz = chain ? LAT : LAT + 5;
    bus.start = 1'b1;
    bus.din   = gen(mode, 0);
    for (int c = 1; c <= horiz; c++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (bus.busy !== (c < LAT)) begin
        n_fail++;
        $display("FAIL busy m%0d c%0d: got %b want %b", mode, c, bus.busy, (c < LAT));
      end
      n_cmp++;
      if (bus.valid !== (c == LAT)) begin
        n_fail++;
        $display("FAIL valid m%0d c%0d: got %b want %b", mode, c, bus.valid, (c == LAT));
      end
      if (c == LAT) begin
        mx = 0;
        for (int i = 0; i < N; i++) if (cnt[i] > mx) mx = cnt[i];
        bi = -1; nmx = 0;
        for (int i = 0; i < N; i++)
          if (cnt[i] == mx) begin
            nmx++;
            if (bi < 0) bi = i;
          end
        exp_idx = bi; exp_max = mx; exp_tie = (nmx > 1);
      end
      n_cmp++;
      if (bus.class_idx !== IDX_W'(exp_idx) || bus.max_count !== (L_LOG2+1)'(exp_max)
          || bus.tie !== exp_tie) begin
        n_fail++;
        $display("FAIL result m%0d c%0d: got idx=%0d cnt=%0d tie=%b want idx=%0d cnt=%0d tie=%b",
                 mode, c, bus.class_idx, bus.max_count, bus.tie, exp_idx, exp_max, exp_tie);
      end
      if (c == LAT && chain) return;
      d = gen(mode, c);
      if (c >= WARMUP + 1 && c <= WARMUP + W_LEN)
        for (int i = 0; i < N; i++) cnt[i] += int'(d[i]);
      bus.din   = d;
      bus.start = inject && (c == 2 || c == 100 || c == LAT - 7);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.start = 1'b1; bus.din = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.class_idx !== '0
        || bus.max_count !== '0 || bus.tie !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got busy=%b valid=%b idx=%0d cnt=%0d tie=%b want all 0",
               bus.busy, bus.valid, bus.class_idx, bus.max_count, bus.tie);
    end
    bus.start = 1'b0; bus.din = '0;
    reset = 1'b0;
    exp_idx = 0; exp_max = 0; exp_tie = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_directed;
    run_window(0, 0, 0);
    run_window(1, 0, 0);
    run_window(2, 0, 0);
    run_window(3, 0, 0);
  endtask

  task automatic test_mid_reset;
    bit seen;
    bus.start = 1'b1; bus.din = gen(4, 0);
    for (int c = 1; c <= WARMUP + 50; c++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL mid_busy c%0d: got %b want 1", c, bus.busy);
      end
      bus.start = 1'b0; bus.din = gen(4, c);
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.class_idx !== '0
        || bus.max_count !== '0 || bus.tie !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b valid=%b idx=%0d cnt=%0d tie=%b want all 0",
               bus.busy, bus.valid, bus.class_idx, bus.max_count, bus.tie);
    end
    exp_idx = 0; exp_max = 0; exp_tie = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < LAT + 10; c++) begin
      @(posedge clk); @(negedge clk);
      if (bus.valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_quiet: got activity=1 want 0");
    end
    run_window(0, 0, 0);
  endtask

  task automatic test_ignored_start;
    run_window(3, 1, 0);
  endtask

  task automatic test_back_to_back;
    run_window(0, 0, 1);
    run_window(2, 0, 1);
    run_window(3, 0, 0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++) run_window(4 + (k % 2), k % 3 == 0, k % 2 == 0);
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
  endtask

  initial begin
    reset = 1'b1; bus.start = 1'b0; bus.din = '0;
    @(negedge clk);
    test_reset;
    test_directed;
    test_mid_reset;
    test_ignored_start;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sc_argmax_decoder.md
Name: sc_argmax_decoder

Overview:
- Downstream stage of the stochastic-computing digit classifier network.
- Consumes the N per-class output bitstreams from the second neuron layer.
- Counts the ones in each stream over a fixed window of 2^L_LOG2 cycles, after a configurable warm-up, then scans the counts sequentially.
- Reports the winning class index, its count and a tie flag with a one-cycle valid pulse.

Parameters:
- N, 10: number of class bitstreams (width of din).
- L_LOG2, 8: log2 of accumulation window length, W_LEN = 2^L_LOG2 cycles.
- WARMUP, 2: cycles after start during which din is ignored (network pipeline settle); 0 allowed.
- IDX_W, 4: width of class index; 2^IDX_W >= N.

Ports:
- clk, input, 1: clock, all state updates on rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: begin a classification window; honoured only in IDLE.
- din, input, N: class bitstreams, bit i = class i, sampled once per cycle in ACCUM.
- busy, output, 1: high whenever state != IDLE.
- valid, output, 1: one-cycle pulse, result outputs newly updated.
- class_idx, output, IDX_W: index of maximum count.
- max_count, output, L_LOG2+1: count of winning class, range 0..2^L_LOG2.
- tie, output, 1: another class index has a count equal to max_count.

Behaviour:
- Reset: state=IDLE; all per-class counters, window counter, warm counter and scan index are 0; busy=0, valid=0, class_idx=0, max_count=0, tie=0. Reset overrides start in the same cycle.
- States: IDLE, WARM, ACCUM, SCAN.
- IDLE, start=1:
  - Clear all N counters (width L_LOG2+1).
  - Go to WARM if WARMUP>0, else go to ACCUM.
  - start=0: stay in IDLE; results hold.
- WARM: exactly WARMUP cycles; din ignored; then go to ACCUM.
- ACCUM: exactly W_LEN cycles.
  - Each cycle, counter[i] += din[i] for all i.
  - No saturation is needed: the maximum value 2^L_LOG2 fits in the counter width.
- SCAN: exactly N cycles, index k = 0..N-1.
  - k=0 loads best=counter[0], best_idx=0, tie_r=0.
  - For k>0, if counter[k] > best: load best=counter[k], best_idx=k, tie_r=0.
  - Else if counter[k] == best: tie_r=1.
  - Strict compare, so the lowest index wins a tie.
- SCAN exit:
  - Go to IDLE.
  - In the first IDLE cycle: valid=1, and class_idx/max_count/tie are updated with best_idx/best/tie_r.
  - Results hold until the next valid pulse; valid returns to 0 the following cycle.
- Latency, with start sampled high in IDLE at cycle t:
  - WARM occupies cycles t+1..t+WARMUP.
  - ACCUM occupies cycles t+WARMUP+1..t+WARMUP+W_LEN.
  - SCAN occupies the next N cycles.
  - valid is high at cycle t+WARMUP+W_LEN+N+1. Defaults: t+269.
- start while busy=1: ignored, no effect on counters or timing.
- start in the cycle valid=1: accepted; the next window begins and outputs still hold the previous result until the next valid.
- Reset mid-operation (WARM, ACCUM or SCAN): immediate return to IDLE with reset values. Outputs go to 0 and no valid is produced for the aborted window.
- Counters are not observable outside; only the scan result is registered to the outputs.

Test Plan:
- Defaults; din[3]=1 constantly, others 0; start at cycle t -> valid at t+269, class_idx=3, max_count=256, tie=0, busy high t+1..t+268.
- din all 0 for the window -> class_idx=0, max_count=0, tie=1.
- din[7] and din[2] both constantly 1 -> class_idx=2, max_count=256, tie=1.
- din[9]=1 only during the 2 WARM cycles; din[5] toggles 1,0,... (128 ones); din[1]=1 every 4th cycle (64 ones) -> class_idx=5, max_count=128, tie=0. Confirms warm-up data is discarded.
- Reset asserted 50 cycles into ACCUM -> busy=0 and outputs 0 next cycle, no valid. A new start then gives a correct result with full 269-cycle latency.
- Second start pulses during ACCUM and SCAN are ignored, giving a single valid at t+269. A start in the valid cycle is accepted, the next valid occurs 269 cycles later, and the previous result holds in between.
